// File: rtl/if_fetch_stage.sv
// if_fetch_stage: ARMv8 instruction fetch with IF/ID register, stall, CB redirect and halt on out-of-range PC
module if_fetch_stage #(
    parameter int IMEM_WORDS = 64,
    parameter int PC_W       = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_if_id,
    output logic [31:0]     instr_if_id,
    output logic            valid_if_id,
    output logic            halted,
    output logic [31:0]     fetch_count,
    output logic [31:0]     flush_count
);
    localparam int AW = $clog2(IMEM_WORDS);
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic [31:0] memory [IMEM_WORDS];
    logic [PC_W-1:0] pc, target;
    logic pc_ok, target_ok;
    logic [31:0] word;
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return c + 32'(c != '1);
    endfunction
    // Full-width compare so any high PC bit counts as out of range
    always_comb begin
        target = branch_target & ~PC_W'(3);
        pc_ok = (pc >> 2) < PC_W'(IMEM_WORDS);
        target_ok = (target >> 2) < PC_W'(IMEM_WORDS);
        word = memory[pc[AW+1:2]];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            pc <= '0;
            pc_if_id <= '0;
            instr_if_id <= '0;
            valid_if_id <= 1'b0;
            halted <= 1'b0;
            fetch_count <= '0;
            flush_count <= '0;
        end else if (state == RUN) begin
            if (branch_taken) begin
                pc <= target;
                instr_if_id <= '0;
                valid_if_id <= 1'b0;
                flush_count <= sat_inc(flush_count);
            end else if (!stall) begin
                pc_if_id <= pc;
                instr_if_id <= pc_ok ? word : '0;
                valid_if_id <= pc_ok;
                if (pc_ok) begin
                    pc <= pc + PC_W'(4);
                    fetch_count <= sat_inc(fetch_count);
                end else begin
                    state <= HALT;
                    halted <= 1'b1;
                end
            end
        end else if (branch_taken) begin
            // IF/ID already holds a bubble in HALT; only a reachable target resumes fetch
            pc <= target;
            if (target_ok) begin
                state <= RUN;
                halted <= 1'b0;
                flush_count <= sat_inc(flush_count);
            end
        end
    end
endmodule
